btn_event_classifier: RTL and testbench

- Downstream consumer of the debounced button stage: takes `pressed`, `press_pulse` and `release_pulse`, plus the shared 1 kHz clock-enable strobe.
- Classifies each gesture as a short click, double click, or long press, and emits auto-repeat pulses while a long press is held.
- All outputs are single-clock-cycle registered pulses, consumed by the menu/control FSM.

---
 rtl/btn_evt_pkg.sv | 22 ++
 rtl/btn_tick_timer.sv | 32 +++
 rtl/btn_event_classifier.sv | 117 +++++++++++
 tb/tb_btn_event_classifier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and elaboration helpers for the button gesture classifier.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HELD1 = 3'd1,
    ST_WAIT2 = 3'd2,
    ST_HELD2 = 3'd3,
    ST_LONG  = 3'd4
  } btn_state_e;

  function automatic int ms_to_ticks(input int ms, input int ce_hz);
    return (ms * ce_hz) / 1000;
  endfunction

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/btn_tick_timer.sv
// Clearable tick-gated saturating up-counter; hit flags the tick that reaches term.
module btn_tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         tick_ce,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] cnt;
  logic [W-1:0] base;
  logic [W:0]   base_inc;

  // A clear takes effect in the same cycle, so a coincident tick counts from zero.
  assign base     = clr ? '0 : cnt;
  assign base_inc = {1'b0, base} + {{W{1'b0}}, 1'b1};
  assign hit      = tick_ce && (base_inc >= {1'b0, term});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick_ce && (base != {W{1'b1}})) begin
      cnt <= base_inc[W-1:0];
    end else begin
      cnt <= base;
    end
  end

endmodule

// File: rtl/btn_event_classifier.sv
// Classifies debounced button gestures into short, double, long and auto-repeat pulses.
module btn_event_classifier
  import btn_evt_pkg::*;
#(
  parameter int CE_HZ     = 1000,
  parameter int LONG_MS   = 800,
  parameter int DOUBLE_MS = 300,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_ce,
  input  logic       pressed,
  input  logic       press_pulse,
  input  logic       release_pulse,
  output logic       short_pulse,
  output logic       double_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [2:0] state_o
);

  localparam int LONG_T = ms_to_ticks(LONG_MS, CE_HZ);
  localparam int DBL_T  = ms_to_ticks(DOUBLE_MS, CE_HZ);
  localparam int REP_T  = ms_to_ticks(REPEAT_MS, CE_HZ);
  localparam int MAX_LD = (LONG_T > DBL_T) ? LONG_T : DBL_T;
  localparam int MAX_T  = (MAX_LD > REP_T) ? MAX_LD : REP_T;
  localparam int W      = clog2(MAX_T + 1);

  if (LONG_T < 1 || DBL_T < 1 || REP_T < 1) begin : g_bad_ticks
    $error("btn_event_classifier: every tick constant must be at least 1");
  end

  btn_state_e   state;
  logic         tmr_clr;
  logic         hit;
  logic [W-1:0] term;
  logic         press_ev;
  logic         release_ev;

  // A release in the same cycle as a press wins; the press is dropped.
  assign press_ev   = press_pulse && !release_pulse;
  assign release_ev = release_pulse || !pressed;
  assign state_o    = state;

  always_comb begin
    term = W'(REP_T);
    if (state == ST_HELD1)      term = W'(LONG_T);
    else if (state == ST_WAIT2) term = W'(DBL_T);
  end

  btn_tick_timer #(.W(W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .tick_ce(tick_ce),
    .term   (term),
    .hit    (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      tmr_clr      <= 1'b0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      tmr_clr      <= 1'b0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press_ev) begin
            state   <= ST_HELD1;
            tmr_clr <= 1'b1;
          end
        end
        ST_HELD1: begin
          if (release_ev) begin
            state   <= ST_WAIT2;
            tmr_clr <= 1'b1;
          end else if (hit) begin
            long_pulse <= 1'b1;
            state      <= ST_LONG;
            tmr_clr    <= 1'b1;
          end
        end
        ST_WAIT2: begin
          if (press_ev) begin
            double_pulse <= 1'b1;
            state        <= ST_HELD2;
          end else if (hit) begin
            short_pulse <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_HELD2: begin
          if (release_ev) state <= ST_IDLE;
        end
        ST_LONG: begin
          if (release_ev) begin
            state <= ST_IDLE;
          end else if (hit) begin
            repeat_pulse <= 1'b1;
            tmr_clr      <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_classifier.sv
// Directed gestures with a pulse scoreboard; expected pulse cycles are hand-computed.
module tb_btn_event_classifier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_ce = 1'b0;
  logic       pressed = 1'b0;
  logic       press_pulse = 1'b0;
  logic       release_pulse = 1'b0;
  logic       short_pulse, double_pulse, long_pulse, repeat_pulse;
  logic [2:0] state_o;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;
  exp_t sb[$];

  localparam int K_SHORT = 0, K_DOUBLE = 1, K_LONG = 2, K_REPEAT = 3;

  btn_event_classifier #(
    .CE_HZ(1000), .LONG_MS(20), .DOUBLE_MS(10), .REPEAT_MS(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_ce      (tick_ce),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .double_pulse (double_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 1 kHz strobe at 100 kHz clk: high during every cycle whose index is a multiple of 100.
  initial forever begin
    @(posedge clk);
    #1;
    tick_ce = (cyc > 0) && (cyc % 100 == 0);
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_at(input int n);
    go_to(n);
    pressed = 1'b1;
    press_pulse = 1'b1;
    go_to(n + 1);
    press_pulse = 1'b0;
  endtask

  task automatic release_at(input int n);
    go_to(n);
    pressed = 1'b0;
    release_pulse = 1'b1;
    go_to(n + 1);
    release_pulse = 1'b0;
  endtask

  // Monitor: any pulse must match the head of the scoreboard in kind and cycle.
  initial begin
    int   n;
    int   k;
    exp_t e;
    forever begin
      @(negedge clk);
      n = int'(short_pulse) + int'(double_pulse) + int'(long_pulse) + int'(repeat_pulse);
      k = short_pulse ? K_SHORT : double_pulse ? K_DOUBLE : long_pulse ? K_LONG : K_REPEAT;
      if (n > 1) begin
        tests++;
        fails++;
        $display("FAIL onehot: %0d pulses high at cycle %0d, expected at most 1", n, cyc);
      end else if (n == 1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
          e = sb.pop_front();
          if (e.kind != k || e.at != cyc) begin
            fails++;
            $display("FAIL pulse: kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                     k, cyc, e.kind, e.at);
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    chk("reset_state", int'(state_o), 0);
    chk("reset_pulses", int'(short_pulse | double_pulse | long_pulse | repeat_pulse), 0);
    go_to(5);
    rst_n = 1'b1;

    // short click: release at 1550, 10th tick at 2500
    push(K_SHORT, 2501);
    press_at(1050);
    go_to(1060);
    chk("t1_held1", int'(state_o), 1);
    release_at(1550);
    go_to(1560);
    chk("t1_wait2", int'(state_o), 2);

    // double click: second press 4 ticks after release
    push(K_DOUBLE, 3951);
    press_at(3050);
    release_at(3550);
    press_at(3950);
    go_to(3960);
    chk("t2_held2", int'(state_o), 3);
    release_at(4250);
    go_to(4260);
    chk("t2_idle", int'(state_o), 0);

    // long press held 37 ms: long at 20th tick, repeats every 5 ticks
    push(K_LONG, 7001);
    push(K_REPEAT, 7501);
    push(K_REPEAT, 8001);
    push(K_REPEAT, 8501);
    press_at(5050);
    go_to(7010);
    chk("t3_long", int'(state_o), 4);
    release_at(8750);
    go_to(8760);
    chk("t3_idle", int'(state_o), 0);

    // release on the 20th tick beats long_pulse
    push(K_SHORT, 12001);
    press_at(9050);
    release_at(11000);
    go_to(11010);
    chk("t4_wait2", int'(state_o), 2);

    // reset 3 ms into WAIT2 discards the pending short click
    press_at(13050);
    release_at(13350);
    go_to(13650);
    chk("t5_pre_reset", int'(state_o), 2);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_state", int'(state_o), 0);
    chk("t5_reset_pulses", int'(short_pulse | double_pulse | long_pulse | repeat_pulse), 0);
    go_to(13700);
    rst_n = 1'b1;

    // pressed drops without a release pulse during LONG
    push(K_LONG, 18001);
    push(K_REPEAT, 18501);
    press_at(16050);
    go_to(18750);
    pressed = 1'b0;
    go_to(18751);
    chk("t6_idle", int'(state_o), 0);

    // second press on the DBL_T timeout tick still gives double
    push(K_DOUBLE, 21501);
    press_at(20050);
    release_at(20550);
    press_at(21500);
    release_at(21700);

    // press and release together in IDLE: release first, press ignored
    go_to(22050);
    pressed = 1'b1;
    press_pulse = 1'b1;
    release_pulse = 1'b1;
    go_to(22051);
    press_pulse = 1'b0;
    release_pulse = 1'b0;
    pressed = 1'b0;
    go_to(22052);
    chk("t8_idle", int'(state_o), 0);

    go_to(23000);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
